score_evaluation_multi: RTL and testbench

Parametrised successor to the single-mole score evaluator for whack-a-mole. It judges button guesses against a mask of simultaneously active moles and applies a combo multiplier to correct hits. Wrong guesses lock input out for a configurable time and can optionally cost a point. It keeps a high score across restarts and sits between the debounced button/guess encoder and the mole generator / seven-segment display logic.

---
 rtl/score_evaluation_multi_if.sv | 36 +++
 rtl/score_evaluation_multi.sv | 167 ++++++++++++++++
 tb/tb_score_evaluation_multi.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/score_evaluation_multi_if.sv
// Guess/score bus between the button encoder, the score evaluator and the
// mole generator / display side. The evaluator is the slave: it receives
// the game controls and the guess, and returns score and pulse outputs.
interface score_evaluation_multi_if #(
  parameter int NUM_HOLES = 8,
  parameter int GUESS_W   = 3,
  parameter int SCORE_W   = 8,
  parameter int COMBO_MAX = 4
);
  localparam int COMBO_W = $clog2(COMBO_MAX + 1);

  logic                 i_restart_game;
  logic                 i_game_over;
  logic                 eval_now;
  logic [GUESS_W-1:0]   user_guess;
  logic [NUM_HOLES-1:0] mole_mask;
  logic                 penalty_en;

  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   high_score;
  logic [COMBO_W-1:0]   combo;
  logic                 guess_correct;
  logic                 guess_wrong;
  logic                 guess_now;
  logic [NUM_HOLES-1:0] hit_mask;

  modport master (
    output i_restart_game, i_game_over, eval_now, user_guess, mole_mask, penalty_en,
    input  score, high_score, combo, guess_correct, guess_wrong, guess_now, hit_mask
  );

  modport slave (
    input  i_restart_game, i_game_over, eval_now, user_guess, mole_mask, penalty_en,
    output score, high_score, combo, guess_correct, guess_wrong, guess_now, hit_mask
  );
endinterface

// File: rtl/score_evaluation_multi.sv
// Multi-mole score evaluator for whack-a-mole. Judges a guessed hole index
// against the mask of raised moles, scores correct hits with a saturating
// combo multiplier, locks input out after a wrong guess and tracks the best
// score across restarts. All outputs come straight from registers.
module score_evaluation_multi #(
  parameter int NUM_HOLES    = 8,
  parameter int GUESS_W      = 3,
  parameter int SCORE_W      = 8,
  parameter int COMBO_MAX    = 4,
  parameter int BLOCK_CYCLES = 100000000,
  parameter int CNT_W        = 27
) (
  input logic                    clk,
  input logic                    rst_n,
  score_evaluation_multi_if.slave bus
);

  localparam int COMBO_W = $clog2(COMBO_MAX + 1);

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_BLOCKED = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [SCORE_W-1:0]   score_r, score_nxt_s;
  logic [SCORE_W-1:0]   high_r, high_nxt_s;
  logic [COMBO_W-1:0]   combo_r, combo_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic                 correct_r, correct_nxt_s;
  logic                 wrong_r, wrong_nxt_s;
  logic                 guess_now_r, guess_now_nxt_s;
  logic [NUM_HOLES-1:0] hit_r, hit_nxt_s;

  logic [NUM_HOLES-1:0] onehot_s;
  logic                 is_hit_s;
  logic [SCORE_W:0]     sum_s;
  logic [SCORE_W-1:0]   score_inc_s;
  logic [SCORE_W-1:0]   score_dec_s;
  logic [COMBO_W-1:0]   combo_inc_s;

  // Decode the guess and precompute the saturating score/combo updates.
  // Guesses at or beyond NUM_HOLES decode to an all-zero one-hot and miss.
  always_comb begin
    onehot_s = {NUM_HOLES{1'b0}};
    for (int i = 0; i < NUM_HOLES; i++) begin
      onehot_s[i] = (bus.user_guess == GUESS_W'(i));
    end
    is_hit_s    = |(onehot_s & bus.mole_mask);
    sum_s       = {1'b0, score_r} + (SCORE_W + 1)'(combo_r);
    score_inc_s = sum_s[SCORE_W] ? {SCORE_W{1'b1}} : sum_s[SCORE_W-1:0];
    score_dec_s = (score_r == {SCORE_W{1'b0}}) ? {SCORE_W{1'b0}}
                                               : score_r - SCORE_W'(1);
    combo_inc_s = (combo_r >= COMBO_W'(COMBO_MAX)) ? COMBO_W'(COMBO_MAX)
                                                   : combo_r + COMBO_W'(1);
  end

  // Next-state and next-output logic; restart beats game over beats eval.
  always_comb begin
    state_nxt_s     = state_r;
    score_nxt_s     = score_r;
    high_nxt_s      = high_r;
    combo_nxt_s     = combo_r;
    cnt_nxt_s       = cnt_r;
    guess_now_nxt_s = guess_now_r;
    correct_nxt_s   = 1'b0;
    wrong_nxt_s     = 1'b0;
    hit_nxt_s       = {NUM_HOLES{1'b0}};

    if (bus.i_restart_game) begin
      state_nxt_s     = ST_PLAY;
      score_nxt_s     = {SCORE_W{1'b0}};
      combo_nxt_s     = COMBO_W'(1);
      cnt_nxt_s       = {CNT_W{1'b0}};
      guess_now_nxt_s = 1'b1;
    end else if (bus.i_game_over) begin
      state_nxt_s     = ST_OVER;
      cnt_nxt_s       = {CNT_W{1'b0}};
      guess_now_nxt_s = 1'b0;
      // Score is frozen once in OVER, so only the entering edge can raise it.
      if ((state_r != ST_OVER) && (score_r > high_r)) begin
        high_nxt_s = score_r;
      end else begin
        high_nxt_s = high_r;
      end
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (bus.eval_now && is_hit_s) begin
            correct_nxt_s = 1'b1;
            hit_nxt_s     = onehot_s;
            score_nxt_s   = score_inc_s;
            combo_nxt_s   = combo_inc_s;
          end else if (bus.eval_now) begin
            wrong_nxt_s     = 1'b1;
            combo_nxt_s     = COMBO_W'(1);
            score_nxt_s     = bus.penalty_en ? score_dec_s : score_r;
            guess_now_nxt_s = 1'b0;
            cnt_nxt_s       = {CNT_W{1'b0}};
            state_nxt_s     = ST_BLOCKED;
          end else begin
            state_nxt_s = ST_PLAY;
          end
        end
        ST_BLOCKED: begin
          if (cnt_r == CNT_W'(BLOCK_CYCLES - 1)) begin
            guess_now_nxt_s = 1'b1;
            cnt_nxt_s       = {CNT_W{1'b0}};
            state_nxt_s     = ST_PLAY;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_OVER: begin
          guess_now_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s     = ST_PLAY;
          guess_now_nxt_s = 1'b1;
          cnt_nxt_s       = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State register for the PLAY/BLOCKED/OVER controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_PLAY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers; high score survives restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_r     <= {SCORE_W{1'b0}};
      high_r      <= {SCORE_W{1'b0}};
      combo_r     <= COMBO_W'(1);
      cnt_r       <= {CNT_W{1'b0}};
      correct_r   <= 1'b0;
      wrong_r     <= 1'b0;
      guess_now_r <= 1'b1;
      hit_r       <= {NUM_HOLES{1'b0}};
    end else begin
      score_r     <= score_nxt_s;
      high_r      <= high_nxt_s;
      combo_r     <= combo_nxt_s;
      cnt_r       <= cnt_nxt_s;
      correct_r   <= correct_nxt_s;
      wrong_r     <= wrong_nxt_s;
      guess_now_r <= guess_now_nxt_s;
      hit_r       <= hit_nxt_s;
    end
  end

  assign bus.score         = score_r;
  assign bus.high_score    = high_r;
  assign bus.combo         = combo_r;
  assign bus.guess_correct = correct_r;
  assign bus.guess_wrong   = wrong_r;
  assign bus.guess_now     = guess_now_r;
  assign bus.hit_mask      = hit_r;

endmodule

// File: tb/tb_score_evaluation_multi.sv
// Self-checking bench for score_evaluation_multi: directed scenarios
// followed by random play, all checked against a behavioural game model.
module tb_score_evaluation_multi;

  localparam int NH = 6;
  localparam int GW = 3;
  localparam int SW = 8;
  localparam int CM = 4;
  localparam int BC = 10;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  score_evaluation_multi_if #(.NUM_HOLES(NH), .GUESS_W(GW), .SCORE_W(SW), .COMBO_MAX(CM)) bus ();

  score_evaluation_multi #(
    .NUM_HOLES(NH), .GUESS_W(GW), .SCORE_W(SW), .COMBO_MAX(CM),
    .BLOCK_CYCLES(BC), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference game state
  int m_score, m_high, m_combo, m_lock, m_correct, m_wrong, m_hit;
  bit m_over;

  function automatic void model_reset(input bit keep_high);
    m_score = 0; m_combo = 1; m_lock = 0; m_over = 1'b0;
    m_correct = 0; m_wrong = 0; m_hit = 0;
    if (!keep_high) m_high = 0;
  endfunction

  function automatic void model_edge(input bit rs, input bit go, input bit ev,
                                     input int g, input int mask, input bit pen);
    m_correct = 0; m_wrong = 0; m_hit = 0;
    if (rs) begin
      model_reset(1'b1);
    end else if (go) begin
      if (!m_over && m_score > m_high) m_high = m_score;
      m_over = 1'b1;
      m_lock = 0;
    end else if (m_over) begin
      // frozen
    end else if (m_lock > 0) begin
      m_lock--;
    end else if (ev) begin
      if (g < NH && ((mask >> g) & 1) == 1) begin
        m_correct = 1;
        m_hit = 1 << g;
        m_score = (m_score + m_combo > 255) ? 255 : m_score + m_combo;
        m_combo = (m_combo + 1 > CM) ? CM : m_combo + 1;
      end else begin
        m_wrong = 1;
        m_combo = 1;
        if (pen && m_score > 0) m_score--;
        m_lock = BC;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":score"},     32'(bus.score),         32'(m_score));
    check({tag, ":high"},      32'(bus.high_score),    32'(m_high));
    check({tag, ":combo"},     32'(bus.combo),         32'(m_combo));
    check({tag, ":correct"},   32'(bus.guess_correct), 32'(m_correct));
    check({tag, ":wrong"},     32'(bus.guess_wrong),   32'(m_wrong));
    check({tag, ":guess_now"}, 32'(bus.guess_now),     32'((!m_over && m_lock == 0) ? 1 : 0));
    check({tag, ":hit_mask"},  32'(bus.hit_mask),      32'(m_hit));
  endtask

  // Apply one cycle of inputs, advance the model on the edge, check #1 later.
  task automatic step(input string tag, input bit rs, input bit go, input bit ev,
                      input int g, input int mask, input bit pen);
    bus.i_restart_game = rs;
    bus.i_game_over    = go;
    bus.eval_now       = ev;
    bus.user_guess     = g[GW-1:0];
    bus.mole_mask      = mask[NH-1:0];
    bus.penalty_en     = pen;
    @(posedge clk);
    model_edge(rs, go, ev, g, mask, pen);
    #1;
    // Moles moving after the judged cycle must not matter.
    bus.mole_mask = ~mask[NH-1:0];
    check_all(tag);
  endtask

  initial begin
    int g;
    bus.i_restart_game = 1'b0;
    bus.i_game_over    = 1'b0;
    bus.eval_now       = 1'b0;
    bus.user_guess     = '0;
    bus.mole_mask      = '0;
    bus.penalty_en     = 1'b0;
    model_reset(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Three held evals on the same mole: score 1,3,6 combo 2,3,4
    for (int i = 0; i < 3; i++) step("hit_run", 0, 0, 1, 2, 'h04, 0);
    check("score_after_run", 32'(bus.score), 32'd6);
    step("idle", 0, 0, 0, 2, 'h04, 0);

    // Wrong guess with penalty, then eval held through the lockout
    step("wrong", 0, 0, 1, 5, 'h04, 1);
    check("score_after_wrong", 32'(bus.score), 32'd5);
    for (int i = 0; i < BC + 1; i++) step("lockout", 0, 0, 1, 2, 'h04, 0);

    // Out-of-range hole indices are always wrong
    step("oob7", 0, 0, 1, 7, 'h3F, 0);
    for (int i = 0; i < BC; i++) step("oob7_lock", 0, 0, 0, 0, 0, 0);
    step("oob6", 0, 0, 1, 6, 'h3F, 0);
    for (int i = 0; i < BC; i++) step("oob6_lock", 0, 0, 0, 0, 0, 0);

    // Underflow: wrong guess with penalty at score 0
    step("restart", 1, 0, 0, 0, 0, 0);
    step("underflow", 0, 0, 1, 1, 'h01, 1);
    for (int i = 0; i < BC; i++) step("uf_lock", 0, 0, 0, 0, 0, 0);

    // Saturation: keep hitting until the score has pinned at the top
    for (int i = 0; i < 72; i++) begin
      g = $urandom_range(0, NH - 1);
      step("saturate", 0, 0, 1, g, (1 << g) | $urandom_range(0, 63), 0);
    end
    check("score_saturated", 32'(bus.score), 32'd255);

    // Game over in the middle of a lockout
    step("wrong_pre_over", 0, 0, 1, 3, 'h00, 1);
    for (int i = 0; i < 3; i++) step("lock_pre_over", 0, 0, 0, 0, 0, 0);
    step("game_over", 0, 1, 1, 2, 'h3F, 0);
    check("high_after_over", 32'(bus.high_score), 32'd254);
    for (int i = 0; i < 3; i++) step("over_ignore", 0, 0, 1, 2, 'h3F, 0);
    step("restart2", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("replay", 0, 0, 1, 0, 'h01, 0);
    step("over_low", 0, 1, 0, 0, 0, 0);
    step("restart3", 1, 0, 0, 0, 0, 0);

    // Restart, game over and eval together: restart wins
    step("simul", 1, 1, 1, 2, 'h04, 0);
    step("simul_next", 0, 1, 1, 2, 'h04, 0);
    step("restart4", 1, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges during a lockout
    step("hit_pre_rst", 0, 0, 1, 4, 'h10, 0);
    step("wrong_pre_rst", 0, 0, 1, 4, 'h00, 0);
    for (int i = 0; i < 3; i++) step("lock_pre_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset(1'b0);
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("async_rst_hold");
    rst_n = 1'b1;

    // Random play
    for (int i = 0; i < 600; i++) begin
      step("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 7),
           $urandom_range(0, 63),
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
